// File: rtl/mxint8_dot_product_chk.sv
// Receive-side checker for the MXINT8 dot-product stream: queues expected
// results, pairs them in order with DUT results, and keeps statistics.
module mxint8_dot_product_chk #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 end_of_test,
  input  logic                 exp_valid,
  output logic                 exp_ready,
  input  logic [31:0]          exp_result,
  input  logic [3:0]           exp_flags,
  input  logic                 dut_valid,
  input  logic [31:0]          dut_result,
  input  logic [3:0]           dut_flags,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic [CNT_WIDTH-1:0] orphan_count,
  output logic                 mismatch,
  output logic                 first_fail_valid,
  output logic [CNT_WIDTH-1:0] first_fail_index,
  output logic [35:0]          first_fail_exp,
  output logic [35:0]          first_fail_got,
  output logic                 done,
  output logic                 timeout,
  output logic                 all_pass
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [AW:0]          FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0]        IDLE_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] idle_cnt;

  logic        active, empty, full;
  logic        push, pop, orphan;
  logic        timeout_set;
  logic [35:0] head, got;
  logic        dut_is_nan, cmp_pass;

  assign active    = (state == S_RUN) || (state == S_DRAIN);
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign exp_ready = active && !full;

  // start has priority over traffic in its own cycle: that cycle only flushes
  assign push   = exp_valid && exp_ready && !start;
  assign pop    = dut_valid && active && !empty && !start;
  assign orphan = dut_valid && active && empty && !start;

  assign head = mem[rd_ptr];
  assign got  = {dut_flags, dut_result};

  // Compare rule: expected NaN accepts any NaN with the DUT NaN flag set
  always_comb begin
    dut_is_nan = (dut_result[30:23] == 8'hFF) && (dut_result[22:0] != '0);
    if (head[35]) cmp_pass = dut_flags[3] && dut_is_nan;
    else          cmp_pass = (head == got);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and timeout detection
  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start)            state_nxt = S_RUN;
        else if (end_of_test) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (start) begin
          state_nxt = S_RUN;
        end else if (empty && !push) begin
          state_nxt = S_DONE;
        end else if (!dut_valid && (idle_cnt == IDLE_MAX)) begin
          state_nxt   = S_DONE;
          timeout_set = 1'b1;
        end
      end
      S_DONE: begin
        if (start) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {exp_flags, exp_result};
  end

  // DRAIN idle counter, restarted by every DUT result
  always_ff @(posedge clk) begin
    if (rst || (state != S_DRAIN) || dut_valid) idle_cnt <= '0;
    else if (idle_cnt != IDLE_MAX)               idle_cnt <= idle_cnt + 1'b1;
  end

  // Statistics, mismatch pulse and first-fail capture
  always_ff @(posedge clk) begin
    if (rst || start) begin
      pass_count       <= '0;
      fail_count       <= '0;
      orphan_count     <= '0;
      mismatch         <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_index <= '0;
      first_fail_exp   <= '0;
      first_fail_got   <= '0;
      timeout          <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (pop) begin
        if (cmp_pass) begin
          if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
        end else begin
          if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
          mismatch <= 1'b1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_index <= pass_count + fail_count;
            first_fail_exp   <= head;
            first_fail_got   <= got;
          end
        end
      end
      if (orphan && (orphan_count != CNT_MAX)) orphan_count <= orphan_count + 1'b1;
      if (timeout_set) timeout <= 1'b1;
    end
  end

  assign done     = (state == S_DONE);
  assign all_pass = done && (fail_count == '0) && (orphan_count == '0) && !timeout && empty;

endmodule

// File: doc/mxint8_dot_product_chk.md
Name: mxint8_dot_product_chk

Overview:
- Receive end of the MXINT8 dot-product test stream. The stimulus driver pushes expected float32 results and flags into this block; the DUT pushes its actual results.
- The block queues expected entries in a FIFO, pairs them in order with DUT results, and compares each pair.
- It keeps pass, fail and orphan counters, captures the first mismatch, and raises done once the stream has drained.
- It is synthesizable, so it serves both the simulation bench and the FPGA self-test wrapper.

Parameters:
- DEPTH, 8: expected-FIFO entries (power of 2, ≥2).
- CNT_WIDTH, 16: width of the pass, fail and orphan counters.
- TIMEOUT, 64: idle cycles allowed in DRAIN before the block declares a timeout.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; IDLE→RUN and clears all statistics.
- end_of_test  in  1  one-cycle pulse; the driver has sent its last expected entry.
- exp_valid  in  1  expected entry is valid.
- exp_ready  out  1  FIFO can accept an entry; equals !full.
- exp_result  in  32  expected float32 result.
- exp_flags  in  4  expected flags {NaN, overflow, underflow, unused}.
- dut_valid  in  1  DUT result is valid; there is no backpressure toward the DUT.
- dut_result  in  32  DUT float32 result.
- dut_flags  in  4  DUT flags, same order as exp_flags.
- pass_count  out  CNT_WIDTH  number of matching pairs.
- fail_count  out  CNT_WIDTH  number of mismatching pairs.
- orphan_count  out  CNT_WIDTH  DUT results that arrived while the FIFO was empty.
- mismatch  out  1  one-cycle pulse, registered, on each failing compare.
- first_fail_valid  out  1  sticky; a first-fail record has been captured.
- first_fail_index  out  CNT_WIDTH  compare index of the first failure, counting from 0.
- first_fail_exp  out  36  {exp_flags, exp_result} of the first failure.
- first_fail_got  out  36  {dut_flags, dut_result} of the first failure.
- done  out  1  sticky; the block is in DONE.
- timeout  out  1  sticky; DRAIN expired with entries still in the FIFO.
- all_pass  out  1  done & no fails & no orphans & !timeout & FIFO empty.

Behaviour:
- **Reset:**
  - The block enters IDLE and the FIFO is emptied.
  - All counters, first_fail_*, mismatch, done, timeout and all_pass are 0.
  - exp_ready is 0 in IDLE, so it is 0 out of reset.
- **States:**
  - IDLE: exp_ready=0; DUT input is ignored. start → RUN and clears statistics.
  - RUN: pushes and compares are active. end_of_test → DRAIN.
  - DRAIN: compares continue and pushes are still accepted. Exits:
    - FIFO empty → DONE.
    - TIMEOUT consecutive cycles with no dut_valid → DONE with timeout=1.
  - DONE: outputs hold. start → RUN and clears statistics. end_of_test is ignored.
  - start in RUN or DRAIN restarts the run: FIFO flushed, statistics cleared.
  - rst has priority over everything, including mid-run.
- **FIFO:**
  - Push when exp_valid & exp_ready.
  - Pop when dut_valid in RUN or DRAIN and the FIFO is non-empty.
  - Simultaneous push and pop on a non-empty FIFO keeps the count unchanged.
  - When full, exp_ready=0 even if a pop happens in the same cycle; no combinational ready path from dut_valid.
  - Pointers wrap modulo DEPTH; there is a separate count register of width log2(DEPTH)+1.
  - Push and pop on an empty FIFO in the same cycle count as an orphan. The pushed entry is stored and is not bypassed.
- **Compare** (combinational on the FIFO head and DUT inputs; results registered, so counters and mismatch update 1 cycle after dut_valid):
  - If expected NaN flag = 1: pass iff dut NaN flag = 1 and dut_result is any NaN (exp = 8'hFF, mantissa ≠ 0). All other bits and flags are ignored.
  - Otherwise: pass iff all 36 bits are equal.
  - A fail increments fail_count and pulses mismatch.
  - The first fail since start latches first_fail_* and sets first_fail_valid.
- **Compare index:** pass_count + fail_count before the update.
- **Orphans:** dut_valid with the FIFO empty in RUN or DRAIN increments orphan_count and performs no compare.
- **Counters:** saturate at all-ones and do not wrap.
- **DRAIN idle counter:** resets on each dut_valid.

Test Plan:
- **Single pass:** start; push {4'b0000, 32'h3F800000}; dut_valid 3 cycles later with the same value; end_of_test.
  → pass_count=1, fail_count=0, done=1, all_pass=1.
- **Mismatch capture:** push 3 entries; DUT returns the matching value for entries 0 and 2; entry 1 is expected 32'h40000000 and the DUT returns 32'h40000001.
  → fail_count=1, first_fail_index=1, first_fail_got[31:0]=32'h40000001, mismatch pulses once.
- **NaN equivalence:** expected flags 4'b1000, result 32'h7FC00000; DUT flags 4'b1000, result 32'h7F800001.
  → pass_count=1.
  - Same expected entry with DUT result 32'h7F800000 → fail.
- **Full and wrap:**
  - Push DEPTH entries with no DUT traffic → exp_ready=0 and count=DEPTH.
  - Then pop and push concurrently for 20 entries → all pass, with FIFO order preserved across pointer wrap.
- **Orphan and timeout:**
  - dut_valid with an empty FIFO in RUN → orphan_count=1.
  - Push 2 entries, end_of_test, no DUT traffic → DONE after 64 cycles with timeout=1 and all_pass=0.
- **Reset mid-run:** rst with 5 entries queued.
  → FIFO empty, counters 0, IDLE, exp_ready=0. The next start followed by a clean run gives all_pass=1.
